// File: rtl/minv_pkg.sv
// Shared definitions for the modular-inverse datapath sequencers.
// Holds the command op encodings, the V-register sequencer state enum and the
// register geometry constants (WORDS words of WW bits = 256 bits).
package minv_pkg;

  localparam int WORDS = 8;
  localparam int WW    = 32;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SHIFT = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_READ  = 2'b11
  } state_e;

endpackage

// File: rtl/minv_reg_ctrl.sv
// Sequencer for the 256-bit modular-inverse V register.
// Accepts one command at a time (LOAD 8 words, SHIFT right N bits, READ 8
// words) and drives the register's we/sel_cyc/sel_rs controls and write port.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_op, cmd_cnt payload
//   din_valid/din_ready, din    LOAD word stream (least-significant word first)
//   dout_valid/dout_ready, dout READ word stream (least-significant word first)
//   reg_in                      register write port (equals din)
//   reg_lsw                     register's current least-significant word
//   reg_we, reg_sel_cyc, reg_sel_rs  register controls
//   busy, done                  non-IDLE flag, one-cycle completion pulse
//   dbg_state, dbg_cnt          FSM state and shared down-counter
//
// Handshake rule for all three streams: a transfer happens on a rising edge
// where valid and ready are both high; valid never depends on ready, and the
// payload is held while valid is high without ready.
module minv_reg_ctrl #(
  parameter int WORDS = minv_pkg::WORDS,
  parameter int WW    = minv_pkg::WW,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_cnt,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [WW-1:0] din,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [WW-1:0] dout,
  output logic [WW-1:0] reg_in,
  input  logic [WW-1:0] reg_lsw,
  output logic          reg_we,
  output logic          reg_sel_cyc,
  output logic          reg_sel_rs,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_cnt
);
  import minv_pkg::*;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_LOAD: begin
              state_d = ST_LOAD;
              cnt_d   = CW'(WORDS - 1);
            end
            OP_READ: begin
              state_d = ST_READ;
              cnt_d   = CW'(WORDS - 1);
            end
            OP_SHIFT: begin
              // A zero-length shift completes like a NOP without touching
              // the register.
              if (cmd_cnt != '0) begin
                state_d = ST_SHIFT;
                cnt_d   = cmd_cnt - 1'b1;
              end else begin
                done_d = 1'b1;
              end
            end
            OP_NOP: done_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_LOAD: begin
        din_ready = 1'b1;
        reg_we    = din_valid;
        if (din_valid) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        reg_we     = 1'b1;
        reg_sel_rs = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_READ: begin
        // Each accepted word rotates the register by one word so the next
        // word reaches reg_lsw; eight rotates restore the original value.
        dout_valid  = 1'b1;
        reg_we      = dout_ready;
        reg_sel_cyc = 1'b1;
        if (dout_ready) begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign reg_in    = din;
  assign dout      = reg_lsw;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_minv_reg_ctrl.sv
module tb_minv_reg_ctrl;
  import minv_pkg::*;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b11;
  logic [CW-1:0] cmd_cnt = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [31:0]   din = '0;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic [31:0]   dout;
  logic [31:0]   reg_in;
  logic [31:0]   reg_lsw;
  logic          reg_we, reg_sel_cyc, reg_sel_rs;
  logic          busy, done;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  minv_reg_ctrl #(.WORDS(8), .WW(32), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .reg_in(reg_in), .reg_lsw(reg_lsw),
    .reg_we(reg_we), .reg_sel_cyc(reg_sel_cyc), .reg_sel_rs(reg_sel_rs),
    .busy(busy), .done(done), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // Behavioural V register (no reset), driven by the DUT controls.
  logic [255:0] v_reg;
  assign reg_lsw = v_reg[31:0];
  always @(posedge clk) begin
    if (reg_we) begin
      if (reg_sel_rs)       v_reg <= v_reg >> 1;
      else if (reg_sel_cyc) v_reg <= {v_reg[31:0], v_reg[255:32]};
      else                  v_reg <= {reg_in, v_reg[255:32]};
    end
  end

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int we_cnt = 0;
  logic [31:0] exp_q[$];   // expected dout words
  int          lat_q[$];   // expected accept-to-done latency, -1 = don't care
  int          acc_q[$];   // cycle of command accept
  logic [255:0] exp_v;     // expected register contents

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we) we_cnt++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("dout_unexpected", {32'd0, dout}, 64'hdead);
        else chk("dout", {32'd0, dout}, {32'd0, exp_q.pop_front()});
      end
      if (done) begin
        if (lat_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          int l, a;
          l = lat_q.pop_front();
          a = acc_q.pop_front();
          if (l >= 0) chk("done_latency", 64'(cyc - a), 64'(l));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input int cnt, input int lat);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CW'(cnt);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cmd_accept_timeout", 64'd0, 64'd1);
    acc_q.push_back(cyc);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_cnt = '0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy && lat_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_load(input logic [255:0] data, input int stall_at, input int lat);
    int base;
    logic [CW-1:0] held;
    base = we_cnt;
    send_cmd(2'b00, 0, lat);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        din_valid = 1'b0;
        held = dbg_cnt;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_we", {63'd0, reg_we}, 64'd0);
          chk("stall_cnt", {56'd0, dbg_cnt}, {56'd0, held});
          @(posedge clk); #1;
        end
      end
      din_valid = 1'b1;
      din = data[32*i +: 32];
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (din_ready) break;
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    wait_done();
    chk("load_we_count", 64'(we_cnt - base), 64'd8);
    exp_v = data;
  endtask

  task automatic do_read(input bit toggle, input int lat);
    int base;
    base = we_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_v[32*i +: 32]);
    send_cmd(2'b10, 0, lat);
    for (int i = 0; i < 40; i++) begin
      dout_ready = toggle ? (i % 2 == 0) : 1'b1;
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
    end
    dout_ready = 1'b0;
    wait_done();
    chk("read_words_left", 64'(exp_q.size()), 64'd0);
    chk("read_we_count", 64'(we_cnt - base), 64'd8);
  endtask

  task automatic do_shift(input int n, input int lat);
    int base;
    base = we_cnt;
    send_cmd(2'b01, n, lat);
    wait_done();
    chk("shift_we_count", 64'(we_cnt - base), 64'(n));
    exp_v = exp_v >> n;
  endtask

  task automatic do_nop();
    int base;
    base = we_cnt;
    send_cmd(2'b11, 0, 1);
    wait_done();
    chk("nop_we_count", 64'(we_cnt - base), 64'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_reg_we", {63'd0, reg_we}, 64'd0);
    chk("rst_din_ready", {63'd0, din_ready}, 64'd0);
    chk("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
    chk("rst_cnt", {56'd0, dbg_cnt}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] d;
    exp_v = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LOAD 0..7 then READ, both 9 cycles.
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'(i);
    do_load(d, -1, 9);
    do_read(1'b0, 9);

    // LOAD with 0x1 in word 0 and 0x80000000 in word 7, SHIFT 1, READ.
    d = '0;
    d[31:0]    = 32'h0000_0001;
    d[255:224] = 32'h8000_0000;
    do_load(d, -1, 9);
    do_shift(1, 2);
    do_read(1'b0, 9);

    // SHIFT 0 and NOP leave the register alone.
    do_shift(0, 1);
    do_nop();
    do_read(1'b0, 9);

    // READ with dout_ready toggling, twice, after a mixed-pattern LOAD.
    d = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hA5A5_5A5A,
         32'hFFFF_0000, 32'h1357_9BDF, 32'h0F0F_F0F0, 32'hCAFE_F00D};
    do_load(d, -1, 9);
    do_read(1'b1, -1);
    do_read(1'b1, -1);

    // LOAD with a 3-cycle din_valid gap before word 4.
    d = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
         32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    do_load(d, 4, -1);
    do_read(1'b0, 9);

    // Multi-bit shift crossing word boundaries.
    do_shift(37, 38);
    do_read(1'b0, 9);

    // Reset in the middle of SHIFT 200, then a full round-trip.
    send_cmd(2'b01, 200, 201);
    repeat (50) @(posedge clk);
    #1;
    chk("busy_mid_shift", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    lat_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'hC000_0000 + 32'(i * 3);
    do_load(d, -1, 9);
    do_read(1'b0, 9);

    repeat (3) @(negedge clk);
    chk("final_done_pending", 64'(lat_q.size()), 64'd0);
    chk("final_words_pending", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
